tick_mod_counter: RTL

TICK_MOD_COUNTER -- requirements
Module: tick_mod_counter

---
 rtl/tick_mod_counter.sv | 94 +++++++++
 1 files changed

// File: rtl/tick_mod_counter.sv
// Prescaled modulo up/down counter with tick and carry pulses for cascading stages.
// Build option: define TMC_LOAD_EN to enable the synchronous clamped load path.
module tick_mod_counter #(
  parameter int WIDTH   = 7,
  parameter int MODULUS = 60,
  parameter int DIV     = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             carry
);

  localparam logic [15:0]      DIV_LAST  = 16'(DIV - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

  logic [15:0]      presc_reg;
  logic [WIDTH-1:0] count_reg;
  logic             tick_reg;
  logic             carry_reg;

  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] count_next;

  assign step = en && (presc_reg == DIV_LAST);

  always_comb begin
    wrap       = 1'b0;
    count_next = count_reg;
    if (up_dn) begin
      wrap       = (count_reg == COUNT_MAX);
      count_next = wrap ? '0 : count_reg + WIDTH'(1);
    end else begin
      wrap       = (count_reg == '0);
      count_next = wrap ? COUNT_MAX : count_reg - WIDTH'(1);
    end
  end

`ifdef TMC_LOAD_EN
  localparam logic [WIDTH:0] MOD_WIDE = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] load_clamped;

  // Out-of-range load values saturate so count can never leave 0..MODULUS-1.
  assign load_clamped = ({1'b0, load_val} >= MOD_WIDE) ? COUNT_MAX : load_val;
`else
  logic unused_load;

  assign unused_load = ^{load, load_val};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_reg <= '0;
      count_reg <= '0;
      tick_reg  <= 1'b0;
      carry_reg <= 1'b0;
    end else if (clr) begin
      presc_reg <= '0;
      count_reg <= '0;
      tick_reg  <= 1'b0;
      carry_reg <= 1'b0;
`ifdef TMC_LOAD_EN
    end else if (load) begin
      presc_reg <= '0;
      count_reg <= load_clamped;
      tick_reg  <= 1'b0;
      carry_reg <= 1'b0;
`endif
    end else if (en) begin
      presc_reg <= step ? '0 : presc_reg + 16'd1;
      if (step) begin
        count_reg <= count_next;
      end
      tick_reg  <= step;
      carry_reg <= step && wrap;
    end else begin
      tick_reg  <= 1'b0;
      carry_reg <= 1'b0;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign carry = carry_reg;

endmodule
